// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multi-cycle CPU controller: ISA opcode/funct values,
// FSM states, instruction classes and the datapath mux select codes.
package cpu_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BGEZ  = 6'h01;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNEZ  = 6'h05;
  localparam logic [5:0] OP_BGT   = 6'h07;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_MUL  = 6'h18;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_SLT  = 6'h2a;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_EXEC_I   = 4'd3,
    S_MEM_ADDR = 4'd4,
    S_MEM_RD   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_WB_R     = 4'd7,
    S_WB_I     = 4'd8,
    S_WB_MEM   = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11,
    S_JAL      = 4'd12,
    S_JR       = 4'd13,
    S_HALT     = 4'd14,
    S_ERR      = 4'd15
  } state_e;

  typedef enum logic [2:0] {
    CLS_R, CLS_JR, CLS_IMM, CLS_LOAD, CLS_STORE, CLS_BRANCH, CLS_JUMP, CLS_JAL
  } instr_class_e;

  localparam logic [2:0] ALU_ADD   = 3'd0;
  localparam logic [2:0] ALU_SUB   = 3'd1;
  localparam logic [2:0] ALU_FUNCT = 3'd2;
  localparam logic [2:0] ALU_OR    = 3'd3;
  localparam logic [2:0] ALU_LUI   = 3'd4;

  localparam logic [1:0] PC_SRC_ALU    = 2'd0;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
  localparam logic [1:0] PC_SRC_JUMP   = 2'd2;
  localparam logic [1:0] PC_SRC_RS     = 2'd3;

  localparam logic [1:0] REG_DST_RT  = 2'd0;
  localparam logic [1:0] REG_DST_RD  = 2'd1;
  localparam logic [1:0] REG_DST_R31 = 2'd2;

  localparam logic [1:0] M2R_ALUOUT = 2'd0;
  localparam logic [1:0] M2R_MDR    = 2'd1;
  localparam logic [1:0] M2R_PC     = 2'd2;

  localparam logic [1:0] SRC_B_RT      = 2'd0;
  localparam logic [1:0] SRC_B_FOUR    = 2'd1;
  localparam logic [1:0] SRC_B_IMM     = 2'd2;
  localparam logic [1:0] SRC_B_IMM_SH2 = 2'd3;

endpackage

// File: rtl/instr_decoder.sv
// Combinational opcode/funct classifier consulted by the controller in DECODE
// and, since the IR is stable, in the states that follow it.
module instr_decoder
  import cpu_ctrl_pkg::*;
(
  input  logic [5:0]   op_i,
  input  logic [5:0]   funct_i,
  output instr_class_e instr_class_o,
  output logic         legal_o
);

  // NOTE: every output gets a default first so no path through the case can infer a latch.
  always_comb begin
    instr_class_o = CLS_R;
    legal_o       = 1'b1;
    case (op_i)
      OP_RTYPE: begin
        case (funct_i)
          FN_JR:  instr_class_o = CLS_JR;
          FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT,
          FN_SLLV, FN_SLL, FN_SRLV, FN_SRL, FN_MUL:
                  instr_class_o = CLS_R;
          default: legal_o = 1'b0;
        endcase
      end
      OP_ADDI, OP_ORI, OP_LUI:          instr_class_o = CLS_IMM;
      OP_LW:                            instr_class_o = CLS_LOAD;
      OP_SW:                            instr_class_o = CLS_STORE;
      OP_BEQ, OP_BGT, OP_BNEZ, OP_BGEZ: instr_class_o = CLS_BRANCH;
      OP_J:                             instr_class_o = CLS_JUMP;
      OP_JAL:                           instr_class_o = CLS_JAL;
      default:                          legal_o       = 1'b0;
    endcase
  end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle control FSM: sequences fetch/decode/execute/memory/write-back over
// a shared, wait-state capable memory port and drives the datapath selects.
module multi_cycle_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int MAX_WAIT = 15,
  parameter int WAIT_W   = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [5:0] op_i,
  input  logic [5:0] funct_i,
  input  logic       instr_zero_i,
  input  logic       eq_i,
  input  logic       gt_i,
  input  logic       nez_i,
  input  logic       gez_i,
  input  logic       mem_ready_i,
  output logic       mem_read_o,
  output logic       mem_write_o,
  output logic       iord_o,
  output logic       ir_write_o,
  output logic       pc_write_o,
  output logic [1:0] pc_src_o,
  output logic       reg_write_o,
  output logic [1:0] reg_dst_o,
  output logic [1:0] mem_to_reg_o,
  output logic       alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [2:0] alu_op_o,
  output logic       halted_o,
  output logic       err_o,
  output logic [3:0] state_o
);

  state_e              state_q, state_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  instr_class_e        instr_class;
  logic                instr_legal;
  logic                branch_taken;
  logic                wait_expired;

  instr_decoder u_instr_decoder (
    .op_i          (op_i),
    .funct_i       (funct_i),
    .instr_class_o (instr_class),
    .legal_o       (instr_legal)
  );

  always_comb begin
    case (op_i)
      OP_BEQ:  branch_taken = eq_i;
      OP_BGT:  branch_taken = gt_i;
      OP_BNEZ: branch_taken = nez_i;
      OP_BGEZ: branch_taken = gez_i;
      default: branch_taken = 1'b0;
    endcase
  end

  assign wait_expired = (wait_q == WAIT_W'(MAX_WAIT));
  assign state_o      = state_q;
  assign halted_o     = (state_q == S_HALT);
  assign err_o        = (state_q == S_ERR);

  // NOTE: sequential state uses non-blocking assignments; reset is synchronous and wins over everything.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_FETCH;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    wait_d       = '0;
    mem_read_o   = 1'b0;
    mem_write_o  = 1'b0;
    iord_o       = 1'b0;
    ir_write_o   = 1'b0;
    pc_write_o   = 1'b0;
    pc_src_o     = PC_SRC_ALU;
    reg_write_o  = 1'b0;
    reg_dst_o    = REG_DST_RT;
    mem_to_reg_o = M2R_ALUOUT;
    alu_src_a_o  = 1'b0;
    alu_src_b_o  = SRC_B_RT;
    alu_op_o     = ALU_ADD;

    case (state_q)
      S_FETCH: begin
        mem_read_o  = 1'b1;
        alu_src_b_o = SRC_B_FOUR;
        if (mem_ready_i) begin
          ir_write_o = 1'b1;
          pc_write_o = 1'b1;
          state_d    = S_DECODE;
        end else if (wait_expired) begin
          state_d = S_ERR;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_DECODE: begin
        alu_src_b_o = SRC_B_IMM_SH2;
        if (instr_zero_i)      state_d = S_HALT;
        else if (!instr_legal) state_d = S_ERR;
        else begin
          case (instr_class)
            CLS_R:                state_d = S_EXEC_R;
            CLS_JR:               state_d = S_JR;
            CLS_IMM:              state_d = S_EXEC_I;
            CLS_LOAD, CLS_STORE:  state_d = S_MEM_ADDR;
            CLS_BRANCH:           state_d = S_BRANCH;
            CLS_JUMP:             state_d = S_JUMP;
            CLS_JAL:              state_d = S_JAL;
            default:              state_d = S_ERR;
          endcase
        end
      end
      S_EXEC_R: begin
        alu_src_a_o = 1'b1;
        alu_op_o    = ALU_FUNCT;
        state_d     = S_WB_R;
      end
      S_WB_R: begin
        reg_write_o = 1'b1;
        reg_dst_o   = REG_DST_RD;
        state_d     = S_FETCH;
      end
      S_EXEC_I: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = SRC_B_IMM;
        case (op_i)
          OP_ORI:  alu_op_o = ALU_OR;
          OP_LUI:  alu_op_o = ALU_LUI;
          default: alu_op_o = ALU_ADD;
        endcase
        state_d = S_WB_I;
      end
      S_WB_I: begin
        reg_write_o = 1'b1;
        state_d     = S_FETCH;
      end
      S_MEM_ADDR: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = SRC_B_IMM;
        state_d     = (instr_class == CLS_STORE) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        mem_read_o = 1'b1;
        iord_o     = 1'b1;
        if (mem_ready_i)       state_d = S_WB_MEM;
        else if (wait_expired) state_d = S_ERR;
        else                   wait_d  = wait_q + 1'b1;
      end
      S_WB_MEM: begin
        reg_write_o  = 1'b1;
        mem_to_reg_o = M2R_MDR;
        state_d      = S_FETCH;
      end
      S_MEM_WR: begin
        mem_write_o = 1'b1;
        iord_o      = 1'b1;
        if (mem_ready_i)       state_d = S_FETCH;
        else if (wait_expired) state_d = S_ERR;
        else                   wait_d  = wait_q + 1'b1;
      end
      S_BRANCH: begin
        alu_src_a_o = 1'b1;
        alu_op_o    = ALU_SUB;
        pc_src_o    = PC_SRC_ALUOUT;
        pc_write_o  = branch_taken;
        state_d     = S_FETCH;
      end
      S_JUMP: begin
        pc_write_o = 1'b1;
        pc_src_o   = PC_SRC_JUMP;
        state_d    = S_FETCH;
      end
      S_JAL: begin
        reg_write_o  = 1'b1;
        reg_dst_o    = REG_DST_R31;
        mem_to_reg_o = M2R_PC;
        pc_write_o   = 1'b1;
        pc_src_o     = PC_SRC_JUMP;
        state_d      = S_FETCH;
      end
      S_JR: begin
        pc_write_o = 1'b1;
        pc_src_o   = PC_SRC_RS;
        state_d    = S_FETCH;
      end
      default: ;  // HALT and ERR hold with everything idle
    endcase

    // An instruction abandoned by reset must not get a last write or request out.
    if (rst_i) begin
      mem_read_o  = 1'b0;
      mem_write_o = 1'b0;
      ir_write_o  = 1'b0;
      pc_write_o  = 1'b0;
      reg_write_o = 1'b0;
    end
  end

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Directed bench for multi_cycle_ctrl: hand-computed per-cycle expectations for
// each instruction class, wait states, timeout, halt, illegal decode and reset.
module tb_multi_cycle_ctrl;
  import cpu_ctrl_pkg::*;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [5:0] op_i, funct_i;
  logic       instr_zero_i, eq_i, gt_i, nez_i, gez_i, mem_ready_i;
  logic       mem_read_o, mem_write_o, iord_o, ir_write_o, pc_write_o;
  logic [1:0] pc_src_o, reg_dst_o, mem_to_reg_o, alu_src_b_o;
  logic       reg_write_o, alu_src_a_o, halted_o, err_o;
  logic [2:0] alu_op_o;
  logic [3:0] state_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  multi_cycle_ctrl #(.MAX_WAIT(15), .WAIT_W(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .op_i(op_i), .funct_i(funct_i),
    .instr_zero_i(instr_zero_i), .eq_i(eq_i), .gt_i(gt_i), .nez_i(nez_i),
    .gez_i(gez_i), .mem_ready_i(mem_ready_i), .mem_read_o(mem_read_o),
    .mem_write_o(mem_write_o), .iord_o(iord_o), .ir_write_o(ir_write_o),
    .pc_write_o(pc_write_o), .pc_src_o(pc_src_o), .reg_write_o(reg_write_o),
    .reg_dst_o(reg_dst_o), .mem_to_reg_o(mem_to_reg_o), .alu_src_a_o(alu_src_a_o),
    .alu_src_b_o(alu_src_b_o), .alu_op_o(alu_op_o), .halted_o(halted_o),
    .err_o(err_o), .state_o(state_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    mem_ready_i = 1'b0;
    cycle();
    cycle();
    rst_i = 1'b0;
    #1;
  endtask

  // Enables/requests packed as {mem_read, mem_write, ir_write, pc_write, reg_write}.
  function automatic logic [4:0] en();
    return {mem_read_o, mem_write_o, ir_write_o, pc_write_o, reg_write_o};
  endfunction

  // Fetch with zero wait states, leaving the bench in DECODE.
  task automatic fetch_to_decode(input logic [5:0] op, input logic [5:0] fn);
    op_i = op; funct_i = fn; mem_ready_i = 1'b1;
    #1;
    check("fetch_en", {27'd0, en()}, 32'b10110);
    cycle();
    check("decode_state", state_o, S_DECODE);
  endtask

  initial begin
    rst_i = 1'b1; op_i = '0; funct_i = '0; instr_zero_i = 1'b0;
    eq_i = 1'b0; gt_i = 1'b0; nez_i = 1'b0; gez_i = 1'b0; mem_ready_i = 1'b0;

    // Reset state
    do_reset();
    check("rst_state", state_o, S_FETCH);
    check("rst_en", {27'd0, en()}, 32'b10000);
    check("rst_flags", {halted_o, err_o}, 2'b00);

    // add: FETCH, DECODE, EXEC_R, WB_R
    fetch_to_decode(OP_RTYPE, FN_ADD);
    check("add_dec_srcb", alu_src_b_o, SRC_B_IMM_SH2);
    check("add_dec_wr", reg_write_o, 1'b0);
    cycle();
    check("add_exec", {state_o, alu_src_a_o, alu_src_b_o, alu_op_o}, {S_EXEC_R, 1'b1, SRC_B_RT, ALU_FUNCT});
    check("add_exec_wr", reg_write_o, 1'b0);
    cycle();
    check("add_wb", {state_o, reg_write_o, reg_dst_o, mem_to_reg_o}, {S_WB_R, 1'b1, REG_DST_RD, M2R_ALUOUT});
    cycle();
    check("add_done", {state_o, reg_write_o}, {S_FETCH, 1'b0});

    // ori: EXEC_I selects the OR ALU op
    fetch_to_decode(OP_ORI, 6'h00);
    cycle();
    check("ori_exec", {state_o, alu_src_b_o, alu_op_o}, {S_EXEC_I, SRC_B_IMM, ALU_OR});
    cycle();
    check("ori_wb", {state_o, reg_write_o, reg_dst_o}, {S_WB_I, 1'b1, REG_DST_RT});
    cycle();

    // lw with three wait states in MEM_RD
    fetch_to_decode(OP_LW, 6'h00);
    cycle();
    check("lw_addr", {state_o, alu_src_a_o, alu_src_b_o, alu_op_o}, {S_MEM_ADDR, 1'b1, SRC_B_IMM, ALU_ADD});
    cycle();
    mem_ready_i = 1'b0;
    #1;
    check("lw_rd1", {state_o, mem_read_o, iord_o}, {S_MEM_RD, 1'b1, 1'b1});
    cycle();
    check("lw_rd2", {state_o, mem_read_o}, {S_MEM_RD, 1'b1});
    cycle();
    check("lw_rd3", {state_o, mem_read_o}, {S_MEM_RD, 1'b1});
    cycle();
    mem_ready_i = 1'b1;
    #1;
    check("lw_rd4", {state_o, mem_read_o}, {S_MEM_RD, 1'b1});
    cycle();
    check("lw_wb", {state_o, mem_read_o, reg_write_o, reg_dst_o, mem_to_reg_o},
          {S_WB_MEM, 1'b0, 1'b1, REG_DST_RT, M2R_MDR});
    cycle();

    // Branch conditions: each branch picks only its own flag
    gt_i = 1'b0; eq_i = 1'b1; nez_i = 1'b1; gez_i = 1'b1;
    fetch_to_decode(OP_BGT, 6'h00);
    cycle();
    check("bgt0", {state_o, pc_write_o, pc_src_o, alu_op_o}, {S_BRANCH, 1'b0, PC_SRC_ALUOUT, ALU_SUB});
    cycle();
    gt_i = 1'b1; eq_i = 1'b0; nez_i = 1'b0; gez_i = 1'b0;
    fetch_to_decode(OP_BGT, 6'h00);
    cycle();
    check("bgt1", {state_o, pc_write_o, pc_src_o}, {S_BRANCH, 1'b1, PC_SRC_ALUOUT});
    cycle();
    fetch_to_decode(OP_BEQ, 6'h00);
    cycle();
    check("beq0", pc_write_o, 1'b0);
    cycle();
    gt_i = 1'b0; gez_i = 1'b1;
    fetch_to_decode(OP_BGEZ, 6'h00);
    cycle();
    check("bgez1", pc_write_o, 1'b1);
    cycle();
    check("br_latency", state_o, S_FETCH);

    // jal and jr
    fetch_to_decode(OP_JAL, 6'h00);
    cycle();
    check("jal", {state_o, reg_write_o, reg_dst_o, mem_to_reg_o, pc_write_o, pc_src_o},
          {S_JAL, 1'b1, REG_DST_R31, M2R_PC, 1'b1, PC_SRC_JUMP});
    cycle();
    fetch_to_decode(OP_RTYPE, FN_JR);
    cycle();
    check("jr", {state_o, pc_write_o, pc_src_o, reg_write_o}, {S_JR, 1'b1, PC_SRC_RS, 1'b0});
    cycle();

    // sw, then reset while MEM_WR is waiting
    fetch_to_decode(OP_SW, 6'h00);
    cycle();
    cycle();
    mem_ready_i = 1'b0;
    #1;
    check("sw_wr", {state_o, mem_write_o, mem_read_o, iord_o}, {S_MEM_WR, 1'b1, 1'b0, 1'b1});
    rst_i = 1'b1;
    #1;
    check("sw_rst_cycle", {27'd0, en()}, 32'd0);
    cycle();
    rst_i = 1'b0;
    #1;
    check("sw_after_rst", {state_o, mem_write_o}, {S_FETCH, 1'b0});

    // Zero instruction word halts, and HALT is absorbing and idle
    instr_zero_i = 1'b1;
    fetch_to_decode(OP_RTYPE, FN_SLL);
    for (int i = 0; i < 20; i++) begin
      cycle();
      check("halt", {state_o, halted_o, err_o, en()}, {S_HALT, 1'b1, 1'b0, 5'b00000});
    end
    instr_zero_i = 1'b0;

    // Illegal opcode after reset
    do_reset();
    check("rst_clear_halt", halted_o, 1'b0);
    fetch_to_decode(6'h3f, 6'h00);
    cycle();
    check("illegal", {state_o, err_o, halted_o, en()}, {S_ERR, 1'b1, 1'b0, 5'b00000});
    cycle();
    check("err_sticky", {state_o, err_o}, {S_ERR, 1'b1});

    // Ready on the last allowed wait cycle still completes the fetch
    do_reset();
    op_i = OP_RTYPE; funct_i = FN_ADD;
    for (int i = 0; i < 15; i++) cycle();
    mem_ready_i = 1'b1;
    #1;
    check("wait15_state", state_o, S_FETCH);
    check("wait15_irw", ir_write_o, 1'b1);
    cycle();
    check("wait15_done", state_o, S_DECODE);

    // Sixteen not-ready cycles in FETCH time out into ERR
    do_reset();
    for (int i = 0; i < 15; i++) cycle();
    check("timeout_c16", state_o, S_FETCH);
    cycle();
    check("timeout_err", {state_o, err_o, en()}, {S_ERR, 1'b1, 5'b00000});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
